mdu_iter: RTL
=============

Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit: successor to the single-cycle ALU decode path.
- Decodes R-type funct codes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO; runs multi-cycle shift-add multiply and restoring divide into HI/LO.
- Sits beside the main ALU in the execute stage. The controller stalls on busy and reads HI/LO via result.

Parameters:
- WIDTH, 32, operand/HI/LO width in bits; must be >= 4 and even.
- CW, $clog2(WIDTH), iteration counter width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when busy=0
- funct  in  6  R-type function code, sampled with start
- a  in  WIDTH  rs operand; dividend/multiplicand; MTHI/MTLO source
- b  in  WIDTH  rt operand; divisor/multiplier
- busy  out  1  high while an iterative operation is in progress
- done  out  1  one-cycle pulse when HI/LO updated by MULT/DIV
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- result  out  WIDTH  combinational: hi if funct=010000 (MFHI), lo if funct=010010 (MFLO), else 0

Behaviour:
- Reset (reset=0, any time, asynchronous): state=IDLE; busy=0, done=0, hi=0, lo=0; counter, accumulators and sign flags cleared. An in-flight operation is discarded with no HI/LO write.
- Funct codes:
  - 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU: iterative.
  - 010001 MTHI: hi<=a at the next edge.
  - 010011 MTLO: lo<=a at the next edge.
  - MTHI/MTLO complete in one cycle; no busy, no done.
  - Any other funct with start: no effect.
- FSM states: IDLE, CALC, FIX.
  - IDLE, start=1, iterative funct: latch operands. Signed ops convert a and b to magnitudes and record sign_q=sa^sb (product/quotient) and sign_r=sa (remainder). Counter=WIDTH-1. Go to CALC; busy=1 from this edge.
  - CALC: one iteration per cycle. Multiply: shift-add over a 2*WIDTH accumulator. Divide: restoring shift-subtract, one quotient bit per cycle. At counter=0 go to FIX; otherwise decrement.
  - FIX: apply two's-complement sign correction. Write hi/lo. Go to IDLE, busy=0, done=1 for exactly one cycle.
- Latency: start accepted at edge E0; hi/lo written at edge E0+WIDTH+1; done high for the cycle after that edge. Back-to-back start is permitted in the done cycle.
- start while busy=1 is ignored, including MTHI/MTLO; funct/a/b changes during busy have no effect.
- Results:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH product, signed or unsigned.
  - DIV/DIVU: lo = quotient truncated toward zero; hi = remainder with sign of the dividend.
- Divide by zero (b=0, signed or unsigned): lo = all ones, hi = a unmodified; normal latency and done.
- Signed overflow (a = most negative, b = -1): lo = most negative value (wrap), hi = 0.
- hi/lo hold their values in all other cycles. result is valid in any cycle, including during busy, where it returns the stale HI/LO.

Test Plan:
- WIDTH=32. MULT a=FFFFFFFD (-3), b=00000005 -> busy for 33 cycles; done at E0+33; hi=FFFFFFFF, lo=FFFFFFF1.
- MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Then MFHI funct -> result=FFFFFFFE.
- DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU a=00000007, b=0 -> lo=FFFFFFFF, hi=00000007. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
- MULT start, then start with MTHI a=12345678 at cycle 5 -> ignored; hi/lo = product only; a later MTHI in IDLE sets hi=12345678 next edge, with no busy and no done.
- DIVU in flight, reset low at cycle 10 -> immediately busy=0, hi=lo=0, no done pulse. After release, a new MULTU 3*4 yields lo=0000000C.
- WIDTH=8 instance: MULT 80*80 -> hi=40, lo=00, latency 9 cycles. Back-to-back start asserted in the done cycle is accepted.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers: shift-add multiply and
// restoring divide, one bit per cycle, with a final sign-correction cycle.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result
);

  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MTLO = 6'b010011;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t             r_state, w_state_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_is_div, r_sign_q, r_sign_r, r_dz, r_done;
  logic [WIDTH-1:0]   r_hi, r_lo;

  // MULT/MULTU/DIV/DIVU share the 0110xx prefix; bit0 selects unsigned, bit1 divide.
  logic             w_iter, w_signed, w_div;
  logic             w_neg_a, w_neg_b;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;

  assign w_iter   = (funct[5:2] == 4'b0110);
  assign w_signed = ~funct[0];
  assign w_div    = funct[1];
  assign w_neg_a  = w_signed & a[WIDTH-1];
  assign w_neg_b  = w_signed & b[WIDTH-1];
  assign w_mag_a  = w_neg_a ? -a : a;
  assign w_mag_b  = w_neg_b ? -b : b;

  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]     w_trial;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_div_acc;

  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Trial subtract of the shifted partial remainder; no borrow means quotient bit 1.
  assign w_trial   = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
  assign w_qbit    = ~w_trial[WIDTH];
  assign w_rem     = w_qbit ? w_trial[WIDTH-1:0] : r_acc[2*WIDTH-2:WIDTH-1];
  assign w_div_acc = {w_rem, r_acc[WIDTH-2:0], w_qbit};

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot, w_remf;

  assign w_prod = r_sign_q ? -r_acc : r_acc;
  assign w_quot = r_dz ? '1 : (r_sign_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
  assign w_remf = r_sign_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start && w_iter) w_state_next = S_CALC;
      S_CALC:  if (r_cnt == '0) w_state_next = S_FIX;
      S_FIX:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (start && w_iter) begin
            r_cnt    <= CW'(WIDTH - 1);
            r_is_div <= w_div;
            r_sign_q <= w_neg_a ^ w_neg_b;
            r_sign_r <= w_neg_a;
            r_dz     <= w_div && (b == '0);
            r_opnd   <= w_div ? w_mag_b : w_mag_a;
            r_acc    <= {{WIDTH{1'b0}}, (w_div ? w_mag_a : w_mag_b)};
          end else if (start && funct == F_MTHI) begin
            r_hi <= a;
          end else if (start && funct == F_MTLO) begin
            r_lo <= a;
          end
        end
        S_CALC: begin
          r_acc <= r_is_div ? w_div_acc : w_mul_acc;
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_remf;
            r_lo <= w_quot;
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    result = '0;
    if (funct == F_MFHI)      result = r_hi;
    else if (funct == F_MFLO) result = r_lo;
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
